// File: rtl/uart_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_lite_pkg
// Description : Shared types and constants for the uart_lite transmit and
//               receive paths.
//               - tx_state_t   : serializer state encoding
//               - PARITY_*     : parity mode selectors
//               - BYTE_W       : data byte width
//               - parity_bit() : parity bit for a byte under a given mode
// Revision    : 1.0 - initial release
// ============================================================================
package uart_lite_pkg;

    localparam int BYTE_W      = 8;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Odd mode makes the total count of ones (data + parity) odd, so the
    // parity bit is the inverted XOR of the data; even mode uses the XOR.
    function automatic logic parity_bit(input logic [BYTE_W-1:0] data,
                                        input int                mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_lite_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_lite_baud_gen
// Description : Restartable divide-by-CLKS_PER_BIT counter.
//               Counts 0..CLKS_PER_BIT-1 while run is high and is held at 0
//               otherwise. restart forces the count back to 0 at the edge.
// Ports       : clk_i    - clock
//               rst_i    - asynchronous active-high reset
//               run      - counter enable
//               restart  - synchronous return to count 0
//               tick     - high in the last cycle of each bit period
//               pre_tick - high in the cycle before tick
// Revision    : 1.0 - initial release
// ============================================================================
module uart_lite_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int               CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (restart || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // tick is deliberately not gated by restart: the caller decides to
    // restart from tick itself at the end of a frame.
    assign tick     = run && (r_cnt == C_LAST);
    assign pre_tick = run && (r_cnt == C_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_lite_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_lite_tx_ctrl
// Description : Transmit controller for the uart_lite FIFO path. Pops bytes
//               from a first-word-fall-through FIFO and serializes each one
//               as start bit, 8 data bits LSB first, optional parity and 1 or
//               2 stop bits. Frames run back-to-back while data is available
//               and the controller is enabled.
// Ports       : clk_i        - clock
//               rst_i        - asynchronous active-high reset
//               enable_i     - permits starting new frames
//               fifo_empty_i - FIFO empty flag
//               fifo_data_i  - FIFO head word (valid when not empty)
//               fifo_rd_o    - FIFO pop strobe (combinational)
//               tx_o         - serial line, idles high (registered)
//               busy_o       - high whenever not idle (registered)
//               tx_done_o    - pulse in the last cycle of a frame (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_lite_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_rd_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    import uart_lite_pkg::*;

    localparam bit C_HAS_PARITY = (PARITY != PARITY_NONE);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] w_shift_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_nxt;
    logic              r_stop_cnt;
    logic              w_stop_cnt_nxt;
    logic              r_parity;
    logic              w_parity_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pop;
    logic              w_tick;
    logic              w_pre_tick;
    logic              w_last_stop;
    logic              w_baud_run;

    assign w_baud_run  = (r_state != ST_IDLE);
    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;

    uart_lite_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run      (w_baud_run),
        .restart  (w_pop),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    // A new byte may be taken either from idle or exactly in the final cycle
    // of the final stop bit, which is what makes frames abut with no gap.
    // The reset term keeps the strobe quiet while reset is held even though
    // the state register already reads idle.
    assign w_pop = !rst_i && enable_i && !fifo_empty_i &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_STOP) && w_last_stop && w_tick));

    assign fifo_rd_o = w_pop;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = tx_o;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        if (C_HAS_PARITY) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[BYTE_W-1:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // A pop overrides whatever the frame logic chose: load the byte,
        // compute its parity once and open the start bit.
        if (w_pop) begin
            w_state_nxt    = ST_START;
            w_shift_nxt    = fifo_data_i;
            w_bit_idx_nxt  = 3'd0;
            w_stop_cnt_nxt = 1'b0;
            w_parity_nxt   = parity_bit(fifo_data_i, PARITY);
            w_tx_nxt       = 1'b0;
        end
    end

    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    // tx_done_o is registered, so it is armed one cycle early (pre_tick)
    // to land in the final cycle of the last stop bit.
    assign w_done_nxt = (r_state == ST_STOP) && w_last_stop && w_pre_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
            tx_done_o  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            tx_o       <= w_tx_nxt;
            busy_o     <= w_busy_nxt;
            tx_done_o  <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_lite_tx_ctrl.md
# uart_lite_tx_ctrl

Transmit-side controller for the uart_lite FIFO path. It drains bytes from the synchronous wrapping transmit FIFO and serializes each one onto the UART line as an 8-bit frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. It owns the FIFO read port; the host only writes the FIFO. Frames go back-to-back with no idle gap while the FIFO holds data and the controller is enabled.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per bit period; must be ≥ 2.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: 1 or 2.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  permits starting new frames.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  8  FIFO head word; first-word fall-through, valid whenever the FIFO is not empty.
- fifo_rd_o  out  1  FIFO pop strobe; one-cycle pulse.
- tx_o  out  1  serial line; idles high.
- busy_o  out  1  high whenever the state is not IDLE.
- tx_done_o  out  1  one-cycle pulse in the last cycle of each frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: fifo_empty_i == 0 and enable_i == 1, evaluated while either:
  - the state is IDLE, or
  - the controller is in the final cycle of the final stop bit.
- fifo_rd_o equals the pop condition combinationally. It is never high in any other cycle and never high when fifo_empty_i == 1.
- On a pop:
  - the shift register loads fifo_data_i at the same edge;
  - parity accumulates from that byte;
  - the state goes to START.
- Bit sequence:
  - START holds tx_o = 0 for one bit period.
  - DATA shifts out bits 0..7, one bit per period.
  - PARITY runs only if PARITY != 0. Odd mode sends the bit that makes the count of ones across data+parity odd; even mode makes it even.
  - STOP holds tx_o = 1 for STOP_BITS periods.
- Frame end: the final stop-bit cycle pulses tx_done_o. The state then goes to START if the pop condition holds, otherwise to IDLE.
- enable_i low mid-frame: the current frame completes; no further pops happen.
- FIFO overwrite-on-full by the writer is invisible to this block. A byte already popped is never affected.
- Reset, including mid-frame:
  - state = IDLE, tx_o = 1, busy_o = 0, tx_done_o = 0;
  - fifo_rd_o is low during reset;
  - all counters clear;
  - any in-flight byte is discarded, not re-read.

## Timing
- tx_o, busy_o and tx_done_o are registered outputs. fifo_rd_o is combinational from state, counters, fifo_empty_i and enable_i.
- Pop at edge N: tx_o goes low and busy_o goes high in cycle N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is (10 + (PARITY != 0) + (STOP_BITS − 1)) × CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle.
- Baud counter:
  - width is $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT−1, and the bit-end tick fires at CLKS_PER_BIT−1;
  - restarts at 0 on every pop;
  - does not run in IDLE.
- Bit index: 3 bits, 0..7. The stop counter is 1 bit.

## Structure
- Shared package uart_lite_pkg holds:
  - the state typedef (IDLE/START/DATA/PARITY/STOP);
  - parity mode constants PARITY_NONE/ODD/EVEN;
  - the byte width constant (8).
- One sub-module, uart_lite_baud_gen: a restartable divide-by-CLKS_PER_BIT counter with inputs clk_i, rst_i, run, restart and output tick. It is reused later by the RX side.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset with the FIFO empty for 100 cycles -> tx_o = 1, busy_o = 0, fifo_rd_o never asserted.
- Byte 0x55, PARITY = 0, STOP_BITS = 1 -> one fifo_rd_o pulse; tx_o = 0,1,0,1,0,1,0,1,0,1, each for 4 cycles (40 cycles total); tx_done_o pulses in cycle 40; busy_o falls in cycle 41.
- FIFO holding 0xA5 then 0x3C -> second fifo_rd_o exactly 40 cycles after the first; no idle cycle between frames; 80 cycles of activity; two tx_done_o pulses.
- Byte 0x07 with PARITY = 2 -> parity bit 1 (44-cycle frame); with PARITY = 1 -> parity bit 0. With STOP_BITS = 2, the frame grows by 4 cycles.
- enable_i dropped during data bit 3 with 2 bytes left in the FIFO -> the current frame completes normally; no fifo_rd_o while enable_i is low; popping resumes in the cycle enable_i returns high.
- rst_i asserted during data bit 5 -> tx_o = 1 and busy_o = 0 without waiting for a clock edge; after release, the next FIFO byte is popped and sent as a full, correct frame.
